// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared instruction-bus request/response types.
package common_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/ifetch_ctrl_pkg.sv
// rtl/ifetch_ctrl_pkg.sv - fetch front-end state encoding and constants.
package ifetch_ctrl_pkg;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } ifetch_state_t;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [63:0] INSTR_BYTES      = 64'd4;

endpackage

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - PC generation and single-outstanding instruction fetch.
module ifetch_ctrl
    import common_pkg::*;
    import ifetch_ctrl_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [31:0] raw_instr,
    output logic [63:0] pc,
    output logic        instr_valid
);

    ifetch_state_t state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   tgt_q, tgt_d;
    logic [31:0]   instr_q, instr_d;
    logic [63:0]   redir_aligned;
    logic [2:0]    unused_bits;

    assign redir_aligned = {redirect_pc[63:2], 2'b00};
    assign unused_bits   = {iresp.addr_ok, redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= PC_RESET;
            tgt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        case (state_q)
            REQ: begin
                if (iresp.data_ok) begin
                    if (redirect_valid) begin
                        pc_d = redir_aligned;
                    end else begin
                        instr_d = pc_q[2] ? iresp.data[63:32] : iresp.data[31:0];
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    tgt_d   = redir_aligned;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                // pc_q keeps the stale address so the bus sees a stable addr until data_ok
                if (redirect_valid) begin
                    tgt_d = redir_aligned;
                end
                if (iresp.data_ok) begin
                    pc_d    = redirect_valid ? redir_aligned : tgt_q;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_aligned;
                    state_d = REQ;
                end else if (!stall_in) begin
                    pc_d    = pc_q + INSTR_BYTES;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_comb begin
        ireq        = '0;
        ireq.valid  = !reset && (state_q != HOLD);
        ireq.addr   = pc_q;
        ireq.size   = MSIZE4;
        instr_valid = !reset && (state_q == HOLD);
        raw_instr   = instr_valid ? instr_q : 32'd0;
        pc          = pc_q;
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl with a bus model and program-order scoreboard.
module tb_ifetch_ctrl;
    import common_pkg::*;
    import ifetch_ctrl_pkg::*;

    localparam logic [63:0] PCR = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stall_in;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        instr_valid;

    always #5 clk = ~clk;

    ifetch_ctrl #(.PC_RESET(PCR)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .raw_instr      (raw_instr),
        .pc             (pc),
        .instr_valid    (instr_valid)
    );

    int checks = 0;
    int errors = 0;

    // Memory image: explicit words where the test plan fixes them, a hash elsewhere.
    logic [31:0] mem [logic [63:0]];

    function automatic logic [31:0] word_at(input logic [63:0] a);
        logic [31:0] h;
        if (mem.exists(a)) return mem[a];
        h = a[31:0] * 32'h9E37_79B1;
        return h ^ a[63:32] ^ 32'h5BD1_E995;
    endfunction

    // Scoreboard state: next instruction owed in program order plus bus transaction tracking.
    logic [63:0] exp_pc;
    logic [63:0] txn_addr;
    bit          in_txn;
    bit          stale;
    bit          exp_new_req;
    bit          exp_iv;
    int          wait_cnt = -1;
    int          lat_min  = 0;
    int          lat_max  = 0;
    int          accepts  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!reset && ireq.valid && wait_cnt < 0)
            wait_cnt = int'($urandom_range(lat_max, lat_min));
        if (!reset && ireq.valid && wait_cnt == 0) begin
            iresp.data_ok = 1'b1;
            iresp.data    = {word_at({ireq.addr[63:3], 3'b100}), word_at({ireq.addr[63:3], 3'b000})};
        end else begin
            iresp.data_ok = 1'b0;
            iresp.data    = {$urandom, $urandom};
        end
        iresp.addr_ok = 1'($urandom_range(1, 0));
        #1;
        if (reset) begin
            chk("rst_req_valid", ireq.valid, 1'b0);
            chk("rst_instr_valid", instr_valid, 1'b0);
            chk("rst_raw_instr", raw_instr, 32'd0);
        end else begin
            chk("valid_xor", ireq.valid ^ instr_valid, 1'b1);
            chk("instr_valid_timing", instr_valid, exp_iv);
            if (!instr_valid) chk("raw_zero", raw_instr, 32'd0);
            if (ireq.valid) begin
                chk("req_size", ireq.size, MSIZE4);
                chk("req_wdata", ireq.data | {56'd0, ireq.strobe}, 64'd0);
            end
            if (in_txn) begin
                chk("txn_valid_held", ireq.valid, 1'b1);
                chk("txn_addr_stable", ireq.addr, txn_addr);
            end
            if (exp_new_req) begin
                chk("new_req_valid", ireq.valid, 1'b1);
                chk("new_req_addr", ireq.addr, exp_pc);
            end
            if (instr_valid) begin
                chk("instr_pc", pc, exp_pc);
                chk("instr_word", raw_instr, word_at(exp_pc));
            end
        end
        if (reset) begin
            exp_pc      = PCR;
            in_txn      = 0;
            stale       = 0;
            exp_new_req = 1;
            exp_iv      = 0;
            wait_cnt    = -1;
        end else begin
            exp_new_req = 0;
            exp_iv      = 0;
            if (ireq.valid) begin
                if (iresp.data_ok) begin
                    if (!stale && !redirect_valid) exp_iv = 1;
                    else exp_new_req = 1;
                    in_txn   = 0;
                    stale    = 0;
                    wait_cnt = -1;
                end else begin
                    in_txn   = 1;
                    txn_addr = ireq.addr;
                    if (redirect_valid) stale = 1;
                    wait_cnt--;
                end
            end
            if (instr_valid) begin
                if (redirect_valid || !stall_in) begin
                    exp_new_req = 1;
                    if (!redirect_valid) accepts++;
                end else begin
                    exp_iv = 1;
                end
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
            else if (instr_valid && !stall_in) exp_pc = exp_pc + 64'd4;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0;
        reset          = 1'b1;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iresp          = '0;
        mem[PCR]          = 32'h0000_0093;
        mem[PCR + 64'd4]  = 32'h0000_0013;

        // Boot
        lat_min = 1; lat_max = 1;
        repeat (3) cycle();
        reset = 1'b0;
        #1;
        chk("boot_valid", ireq.valid, 1'b1);
        chk("boot_addr", ireq.addr, PCR);
        cycle();
        cycle();
        chk("boot_iv", instr_valid, 1'b1);
        chk("boot_raw", raw_instr, 32'h0000_0093);
        chk("boot_pc", pc, PCR);

        // Zero-wait stream
        lat_min = 0; lat_max = 0;
        cycle();
        chk("stream_addr1", ireq.addr, PCR + 64'd4);
        cycle();
        chk("stream_raw1", raw_instr, 32'h0000_0013);
        cycle();
        chk("stream_addr2", ireq.addr, PCR + 64'd8);
        cycle();
        chk("stream_iv2", instr_valid, 1'b1);
        cycle();
        chk("stream_pulse", instr_valid, 1'b0);
        cycle();

        // Backpressure in HOLD
        stall_in = 1'b1;
        repeat (5) begin
            cycle();
            chk("bp_pc", pc, PCR + 64'd12);
            chk("bp_req_valid", ireq.valid, 1'b0);
        end
        stall_in = 1'b0;
        acc0 = accepts;
        lat_min = 3; lat_max = 3;
        cycle();
        chk("bp_one_accept", 64'(accepts - acc0), 64'd1);
        chk("bp_next_addr", ireq.addr, PCR + 64'd16);

        // Redirect while request in flight
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = PCR + 64'h100;
        cycle();
        redirect_valid = 1'b0;
        chk("rif_addr_hold", ireq.addr, PCR + 64'd16);
        cycle();
        chk("rif_addr_hold2", ireq.addr, PCR + 64'd16);
        cycle();
        chk("rif_no_instr", instr_valid, 1'b0);
        chk("rif_new_addr", ireq.addr, PCR + 64'h100);
        lat_min = 0; lat_max = 0;
        cycle();
        chk("rif_pc", pc, PCR + 64'h100);

        // Redirect in HOLD under stall
        stall_in       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = PCR + 64'h203;
        cycle();
        redirect_valid = 1'b0;
        stall_in       = 1'b0;
        chk("rh_valid", ireq.valid, 1'b1);
        chk("rh_addr", ireq.addr, PCR + 64'h200);

        // Reset mid-request
        lat_min = 5; lat_max = 5;
        cycle();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", ireq.valid, 1'b0);
        chk("mid_rst_raw", raw_instr, 32'd0);
        cycle();
        reset = 1'b0;
        #1;
        chk("post_rst_valid", ireq.valid, 1'b1);
        chk("post_rst_addr", ireq.addr, PCR);

        // Randomized traffic
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(199, 0) == 0);
            stall_in       = 1'($urandom_range(1, 0));
            redirect_valid = ($urandom_range(9, 0) == 0);
            if ($urandom_range(3, 0) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
            else
                redirect_pc = PCR + 64'($urandom_range(4095, 0));
            cycle();
        end
        reset = 1'b0;
        redirect_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
